uart_rx_ctrl: RTL

Sequencing and host-interface controller for the UART receive engine. It drives the engine's baud, EIGHT and PEN configuration, and applies host configuration writes only while the engine is idle. It tracks each frame from the engine's START pulse to its DONE pulse and captures the received byte into a host-visible holding register with ready, overflow and error flags. A bit-period watchdog returns the controller to idle after a false start, which produces no DONE.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_ctrl_if.sv | 34 +++
 rtl/uart_rx_watchdog.sv | 23 ++
 rtl/uart_rx_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: config width, watchdog
// width, FSM state encoding and the per-baud bit-period table.
package uart_pkg;

  localparam int unsigned CFG_W = 6;
  localparam int unsigned WD_W  = 23;
  localparam int unsigned BP_W  = 19;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    WAIT_CLR = 2'd2
  } state_e;

  // Bit period in system clocks (100 MHz) for each baud select code.
  function automatic logic [BP_W-1:0] bit_period(input logic [3:0] baud);
    case (baud)
      4'h0:    return 19'd333333;
      4'h1:    return 19'd83333;
      4'h2:    return 19'd41667;
      4'h3:    return 19'd20833;
      4'h4:    return 19'd10417;
      4'h5:    return 19'd5208;
      4'h6:    return 19'd2604;
      4'h7:    return 19'd1736;
      4'h8:    return 19'd868;
      4'h9:    return 19'd434;
      4'hA:    return 19'd217;
      4'hB:    return 19'd109;
      default: return 19'd333333;
    endcase
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Host and engine signal bundle for uart_rx_ctrl; slave is the controller side.
interface uart_rx_ctrl_if;
  import uart_pkg::*;

  logic             cfg_wr;
  logic [CFG_W-1:0] cfg_data;
  logic             cfg_pending;
  logic [3:0]       baud;
  logic             eight;
  logic             pen;
  logic             eng_start;
  logic             eng_done;
  logic [7:0]       eng_data;
  logic             eng_perr;
  logic             eng_ferr;
  logic             rd;
  logic [7:0]       rx_data;
  logic             rxrdy;
  logic             ovf;
  logic             perr;
  logic             ferr;
  logic             irq;

  modport master (
    output cfg_wr, cfg_data, eng_start, eng_done, eng_data, eng_perr, eng_ferr, rd,
    input  cfg_pending, baud, eight, pen, rx_data, rxrdy, ovf, perr, ferr, irq
  );

  modport slave (
    input  cfg_wr, cfg_data, eng_start, eng_done, eng_data, eng_perr, eng_ferr, rd,
    output cfg_pending, baud, eight, pen, rx_data, rxrdy, ovf, perr, ferr, irq
  );

endinterface

// File: rtl/uart_rx_watchdog.sv
// Loadable down-counter that flags a frame which never produced DONE.
module uart_rx_watchdog
  import uart_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            en,
  input  logic [WD_W-1:0] load_val,
  output logic            zero_c
);

  logic [WD_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - WD_W'(1);
  end

  assign zero_c = (cnt == '0);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencing/host controller. Optional sticky parity/framing
// error flags are built when UART_RX_ERR_EN is defined.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter logic [CFG_W-1:0] RST_CFG  = 6'b1011_1_0,
  parameter int unsigned      TMO_BITS = 12
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_ctrl_if.slave  bus
);

  localparam logic [1:0] S_IDLE     = IDLE;
  localparam logic [1:0] S_RECV     = RECV;
  localparam logic [1:0] S_WAIT_CLR = WAIT_CLR;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             capture_c;
  logic             accept_c;
  logic             apply_c;
  logic             wd_load_c;
  logic             wd_en_c;
  logic             wd_zero_c;
  logic [WD_W-1:0]  wd_val_c;
  logic [CFG_W-1:0] shadow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture_c = 1'b0;
    apply_c   = 1'b0;
    wd_load_c = 1'b0;
    wd_en_c   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.eng_start) begin
          state_nxt = S_RECV;
          wd_load_c = 1'b1;
        end else begin
          apply_c = 1'b1;
        end
      end
      S_RECV: begin
        if (bus.eng_done) begin
          capture_c = 1'b1;
          state_nxt = S_WAIT_CLR;
        end else if (wd_zero_c) begin
          state_nxt = S_IDLE;
        end else begin
          wd_en_c = 1'b1;
        end
      end
      S_WAIT_CLR: begin
        if (!bus.eng_done) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A byte is accepted if the holding register is free or being read this cycle.
  assign accept_c = capture_c && (!bus.rxrdy || bus.rd);
  assign wd_val_c = WD_W'(TMO_BITS * 32'(bit_period(bus.baud)));

  uart_rx_watchdog u_wd (
    .clk      (clk),
    .rst      (rst),
    .load     (wd_load_c),
    .en       (wd_en_c),
    .load_val (wd_val_c),
    .zero_c   (wd_zero_c)
  );

  // Shadowed configuration; copied to the engine only between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow                       <= RST_CFG;
      {bus.baud, bus.eight, bus.pen} <= RST_CFG;
      bus.cfg_pending              <= 1'b0;
    end else begin
      if (apply_c) {bus.baud, bus.eight, bus.pen} <= shadow;
      if (bus.cfg_wr) begin
        shadow          <= bus.cfg_data;
        bus.cfg_pending <= 1'b1;
      end else if (apply_c) begin
        bus.cfg_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rx_data <= '0;
      bus.rxrdy   <= 1'b0;
      bus.ovf     <= 1'b0;
      bus.irq     <= 1'b0;
    end else begin
      bus.irq <= capture_c;
      if (capture_c) begin
        if (accept_c) begin
          bus.rx_data <= bus.eng_data;
          bus.rxrdy   <= 1'b1;
          if (bus.rd) bus.ovf <= 1'b0;
        end else begin
          bus.ovf <= 1'b1;
        end
      end else if (bus.rd && bus.rxrdy) begin
        bus.rxrdy <= 1'b0;
        bus.ovf   <= 1'b0;
      end
    end
  end

`ifdef UART_RX_ERR_EN
  // A read alongside an accepted byte restarts the error history from that byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.perr <= 1'b0;
      bus.ferr <= 1'b0;
    end else if (accept_c) begin
      bus.perr <= (bus.perr & ~bus.rd) | bus.eng_perr;
      bus.ferr <= (bus.ferr & ~bus.rd) | bus.eng_ferr;
    end else if (!capture_c && bus.rd && bus.rxrdy) begin
      bus.perr <= 1'b0;
      bus.ferr <= 1'b0;
    end
  end
`else
  logic unused_err;
  assign unused_err = bus.eng_perr | bus.eng_ferr;
  assign bus.perr   = 1'b0;
  assign bus.ferr   = 1'b0;
`endif

endmodule
